// File: rtl/fir_da_pkg.sv
// Shared constants for the FIR-to-DAC output stage.
// Holds the default stream/DAC geometry and the DAC midscale code.
package fir_da_pkg;

    localparam int unsigned IN_WIDTH   = 23;   // filter sample width (signed)
    localparam int unsigned OUT_WIDTH  = 8;    // DAC word width
    localparam int unsigned SHIFT      = 15;   // IN_WIDTH - SHIFT == OUT_WIDTH
    localparam int unsigned FIFO_DEPTH = 8;    // power of two, >= 2
    localparam int unsigned DIV        = 714;  // CLK cycles per DAC sample, even, >= 4

    localparam logic [7:0] DA_MIDSCALE = 8'h80;

endpackage

// File: rtl/fir_da_fifo.sv
// Synchronous FIFO buffering converted DAC words.
// Ports:
//   clk, rst_n  clock, async active-low reset (empties the FIFO)
//   push, wdata write one word (caller never pushes when full)
//   pop         read one word (ignored when empty)
//   rdata_c     head-of-queue word, combinational from storage
//   full, empty registered status flags
//   count       registered occupancy, 0..DEPTH
module fir_da_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CW-1:0]    count_next_c;

    // Qualified operations and next occupancy
    always_comb begin
        do_push_c    = push && !full;
        do_pop_c     = pop && !empty;
        count_next_c = count + CW'(do_push_c) - CW'(do_pop_c);
    end

    assign rdata_c = mem[rd_ptr];

    // Pointers, occupancy and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next_c;
            full  <= (count_next_c == CNT_FULL);
            empty <= (count_next_c == '0);
        end
    end

    // Storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fir_da_sink.sv
// Output stage between the low-pass FIR and the 8-bit DAC pins.
// Rounds/saturates each Avalon-ST sample to an offset-binary DAC word,
// buffers it, and releases one word per DIV clocks with a local DA_CLK.
// Build option: FIR_DA_SAT_EN enables saturation; without it the rounded
// value wraps to its low OUT_WIDTH bits.
// Ports:
//   CLK, RSTn        system clock, async active-low reset
//   ast_sink_data    signed filter sample
//   ast_sink_valid   sample present
//   ast_sink_error   nonzero: sample is consumed and discarded
//   ast_sink_ready   registered; room for one more sample
//   DA_CLK           DAC latch clock, low for the first half of each period
//   DA_Data          offset-binary DAC word, updated at the pacing tick
//   Underrun         sticky: a tick found the buffer empty
//   Err_Drop         sticky: an error sample was discarded
module fir_da_sink #(
    parameter int unsigned IN_WIDTH   = fir_da_pkg::IN_WIDTH,
    parameter int unsigned OUT_WIDTH  = fir_da_pkg::OUT_WIDTH,
    parameter int unsigned SHIFT      = fir_da_pkg::SHIFT,
    parameter int unsigned FIFO_DEPTH = fir_da_pkg::FIFO_DEPTH,
    parameter int unsigned DIV        = fir_da_pkg::DIV
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [IN_WIDTH-1:0]  ast_sink_data,
    input  logic                 ast_sink_valid,
    input  logic [1:0]           ast_sink_error,
    output logic                 ast_sink_ready,
    output logic                 DA_CLK,
    output logic [OUT_WIDTH-1:0] DA_Data,
    output logic                 Underrun,
    output logic                 Err_Drop
);

    localparam int unsigned SUM_W = IN_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [SUM_W-1:0]     ROUND_K   = SUM_W'(1) << (SHIFT - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_HALF  = CNT_W'(DIV / 2);
    localparam logic [OCC_W:0]       OCC_LIMIT = (OCC_W + 1)'(FIFO_DEPTH);
    localparam logic [OUT_WIDTH-1:0] MIDSCALE  = OUT_WIDTH'(fir_da_pkg::DA_MIDSCALE);

    logic                     accept_c;
    logic                     bad_c;
    logic                     good_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic [OUT_WIDTH-1:0]     sat_c;
    logic [OUT_WIDTH-1:0]     word_c;
`ifdef FIR_DA_SAT_EN
    logic signed [OUT_WIDTH:0] r_c;
`endif

    logic                     conv_valid;
    logic [OUT_WIDTH-1:0]     conv_word;

    logic                     push_c;
    logic                     pop_c;
    logic                     tick_c;
    logic [OUT_WIDTH-1:0]     fifo_rdata_c;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [OCC_W-1:0]         fifo_count;
    logic [OCC_W-1:0]         occ_next_c;
    logic                     ready_next_c;

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_next_c;

    // Handshake qualification
    always_comb begin
        accept_c = ast_sink_valid && ast_sink_ready;
        bad_c    = (ast_sink_error != 2'b00);
        good_c   = accept_c && !bad_c;
    end

    // Round half up, arithmetic shift, optional saturation, offset binary
    always_comb begin
        sum_c = $signed({ast_sink_data[IN_WIDTH-1], ast_sink_data}) + $signed(ROUND_K);
`ifdef FIR_DA_SAT_EN
        r_c = (OUT_WIDTH + 1)'(sum_c >>> SHIFT);
        if (r_c[OUT_WIDTH] != r_c[OUT_WIDTH-1]) begin
            sat_c = r_c[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH - 1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else begin
            sat_c = r_c[OUT_WIDTH-1:0];
        end
`else
        sat_c = OUT_WIDTH'(sum_c >>> SHIFT);
`endif
        word_c = {~sat_c[OUT_WIDTH-1], sat_c[OUT_WIDTH-2:0]};
    end

    // Pacing, FIFO traffic and next-cycle ready
    always_comb begin
        tick_c       = (cnt == '0);
        cnt_next_c   = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        pop_c        = tick_c && !fifo_empty;
        push_c       = conv_valid && !fifo_full;
        occ_next_c   = fifo_count + OCC_W'(push_c) - OCC_W'(pop_c);
        // Buffered words plus the word that will sit in the conversion stage
        ready_next_c = (({1'b0, occ_next_c} + (OCC_W + 1)'(good_c)) < OCC_LIMIT);
    end

    fir_da_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RSTn),
        .push    (push_c),
        .wdata   (conv_word),
        .pop     (pop_c),
        .rdata_c (fifo_rdata_c),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Conversion stage, pacing counter, DAC outputs and sticky flags
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            conv_valid     <= 1'b0;
            conv_word      <= '0;
            cnt            <= '0;
            DA_CLK         <= 1'b0;
            DA_Data        <= MIDSCALE;
            Underrun       <= 1'b0;
            Err_Drop       <= 1'b0;
            ast_sink_ready <= 1'b0;
        end else begin
            conv_valid <= good_c;
            if (good_c) begin
                conv_word <= word_c;
            end
            cnt            <= cnt_next_c;
            DA_CLK         <= (cnt_next_c >= CNT_HALF);
            ast_sink_ready <= ready_next_c;
            if (pop_c) begin
                DA_Data <= fifo_rdata_c;
            end
            if (tick_c && fifo_empty) begin
                Underrun <= 1'b1;
            end
            if (accept_c && bad_c) begin
                Err_Drop <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fir_da_sink.md
# fir_da_sink

Output stage between the low-pass FIR and the 8-bit DAC pins. Accepts the filter's 23-bit Avalon-ST source stream, rounds and saturates each sample to 8 bits, and buffers it in a small FIFO. Samples are released to the DAC at a fixed output rate, with DA_CLK generated locally. It replaces the direct `data_out[22:15]` slice and makes output pacing independent of filter burstiness.

## Interface
- IN_WIDTH, 23: width of filter output sample (signed two's complement).
- OUT_WIDTH, 8: DAC word width.
- SHIFT, 15: right-shift applied before rounding (IN_WIDTH−SHIFT = OUT_WIDTH).
- FIFO_DEPTH, 8: sample buffer entries (power of two, ≥2).
- DIV, 714: CLK cycles per DAC output sample (≥4, even).
- CLK  in  1  system clock; the upstream stream is synchronous to it.
- RSTn  in  1  reset; one clock; reset is asynchronous and active-low.
- ast_sink_data  in  IN_WIDTH  filter output sample.
- ast_sink_valid  in  1  sample present.
- ast_sink_error  in  2  nonzero marks the sample bad.
- ast_sink_ready  out  1  block can accept a sample this cycle.
- DA_CLK  out  1  DAC latch clock; DAC samples on its rising edge.
- DA_Data  out  OUT_WIDTH  offset-binary DAC word.
- Underrun  out  1  sticky: a pacing tick found the FIFO empty.
- Err_Drop  out  1  sticky: a sample with nonzero error was discarded.

## Operation
- Handshake: transfer occurs when ast_sink_valid && ast_sink_ready. ast_sink_ready = 0 in reset, else = (occupancy + pending conversion) < FIFO_DEPTH. Ready does not depend combinationally on valid.
- Error samples: a transfer with ast_sink_error ≠ 0 is consumed but not written; Err_Drop sets.
- Conversion, registered one stage: r = (x + 2^(SHIFT−1)) >>> SHIFT, computed at IN_WIDTH+1 bits (round half up, arithmetic shift). Saturate r to [−128, 127]. Output word = {~r[7], r[6:0]}, i.e. offset binary.
- FIFO: converted word is pushed the cycle after the handshake. A pop and a push in the same cycle are both honored. Push never occurs when full, guaranteed by the ready rule.
- Pacing counter: counts 0..DIV−1 and wraps. Tick is asserted at count == 0.
- On tick, if the FIFO is non-empty: pop and load DA_Data.
- On tick, if the FIFO is empty: hold DA_Data and set Underrun.
- DA_CLK = 0 for counts 0..DIV/2−1 and 1 for DIV/2..DIV−1. Data therefore changes near the falling edge and is stable half a period before the rising edge.
- Sticky flags clear only on reset.
- Reset mid-operation: FIFO emptied, conversion stage discarded, counter returns to 0.

## Timing
- Reset values: DA_Data = 8'h80 (midscale), DA_CLK = 0, ast_sink_ready = 0, Underrun = 0, Err_Drop = 0, counter = 0.
- ast_sink_ready rises on the first CLK edge after RSTn deasserts.
- Handshake at edge N: word is in the FIFO after edge N+1 and is visible to the pop logic at edge N+2.
- Tick pop: DA_Data is updated on the edge where count == 0, so DA_Data changes in the same cycle DA_CLK falls.
- Throughput: one transfer per cycle until full. Sustained output rate is CLK/DIV.

## Configuration
- FIR_DA_SAT_EN defined: saturation as described.
- FIR_DA_SAT_EN undefined: r is truncated to its low 8 bits (wrap-around). Rounding is kept, and no saturation logic is generated.

## Structure
- Package fir_da_pkg holds the default constants (IN_WIDTH, OUT_WIDTH, SHIFT, DIV, FIFO_DEPTH) and the DA_MIDSCALE = 8'h80 constant.
- Sub-module fir_da_fifo: synchronous FIFO (push, pop, full, empty, count; async active-low reset).
- Conversion, pacing and DA_CLK generation stay in fir_da_sink.

## Test plan
- Reset then idle, no valid → DA_Data = 8'h80 and DA_CLK toggling with period DIV. Underrun sets at the first tick (count 0 after reset).
- Push samples 23'h000000, 23'h004000, 23'h008000, 23'h400000 → successive ticks output 8'h80, 8'h81, 8'h81, 8'h00.
- Push 23'h3FFFFF → 8'hFF with FIR_DA_SAT_EN. Without the macro → 8'h00 (wraps).
- Hold valid high with DIV = 714 → ast_sink_ready drops after 8 accepted samples (9 in flight including the conversion stage is not allowed). It re-asserts for exactly one transfer per tick, and no sample is lost or duplicated.
- Valid sample with ast_sink_error = 2'b01 between two good samples → only the good samples appear on DA_Data, and Err_Drop = 1.
- Assert RSTn low with 5 samples buffered, mid-period → all outputs immediately return to their reset values. After release, the first tick outputs only newly pushed data.
